lift_scan_ctrl: RTL and testbench

Parametrised elevator controller. It succeeds the fixed 9-floor, single-request lift FSM. Requests from any number of floors accumulate in a pending bitmap and are served in SCAN order: keep the current direction while requests lie ahead, then reverse. Travel time per floor and door dwell time are timed by counters. The block drives the current floor, the next target, the movement code and the door indicators consumed by the 7-seg/LCD display logic in the top level.

---
 rtl/lift_scan_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_lift_scan_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lift_scan_ctrl.sv
// SCAN-order elevator controller: pending-request bitmap, per-floor travel and door dwell timers.
// Latency: strobe to oPending 1 edge, to oMove 2 edges; backpressure: none, requests are always accepted.
module lift_scan_ctrl #(
  parameter int FLOORS     = 9,
  parameter int FLOOR_W    = 4,
  parameter int CNT_W      = 28,
  parameter int TRAVEL_CYC = 50000000,
  parameter int DOOR_CYC   = 100000000
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic [FLOORS-1:0]  iReq,
  input  logic               iReq_stb,
  output logic [FLOOR_W-1:0] oFloor,
  output logic [FLOOR_W-1:0] oTarget,
  output logic [1:0]         oMove,
  output logic               oDoor_open,
  output logic               oDoor_closed,
  output logic [FLOORS-1:0]  oPending,
  output logic               oArrive
);

  typedef enum logic [1:0] {IDLE, MOVING, DOOR_OPEN} state_t;

  localparam logic [1:0]        MV_STOP     = 2'd0;
  localparam logic [1:0]        MV_UP       = 2'd1;
  localparam logic [1:0]        MV_DN       = 2'd2;
  localparam logic [CNT_W-1:0]  TRAVEL_LAST = CNT_W'(TRAVEL_CYC - 1);
  localparam logic [CNT_W-1:0]  DOOR_LAST   = CNT_W'(DOOR_CYC - 1);
  localparam logic [FLOORS-1:0] BIT0        = {{(FLOORS-1){1'b0}}, 1'b1};

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   timer, timer_nxt;
  logic               dir_up, dir_up_nxt;
  logic [FLOOR_W-1:0] floor_nxt, target_nxt, step_floor;
  logic [1:0]         move_nxt;
  logic               door_nxt, arrive_nxt;
  logic [FLOORS-1:0]  pending_nxt, req_set, req_clr, cur_mask, step_mask;
  logic               restart;
  logic               above, below;
  logic [FLOOR_W-1:0] up_near, dn_near;

  // Nearest pending floor strictly above and strictly below the car.
  always_comb begin
    above   = 1'b0;
    below   = 1'b0;
    up_near = oFloor;
    dn_near = oFloor;
    for (int f = FLOORS - 1; f >= 0; f--) begin
      if (oPending[f] && (f > int'(oFloor))) begin
        above   = 1'b1;
        up_near = FLOOR_W'(f);
      end
    end
    for (int f = 0; f < FLOORS; f++) begin
      if (oPending[f] && (f < int'(oFloor))) begin
        below   = 1'b1;
        dn_near = FLOOR_W'(f);
      end
    end
  end

  always_comb begin
    target_nxt = oFloor;
    if (dir_up) begin
      if (above)      target_nxt = up_near;
      else if (below) target_nxt = dn_near;
    end else begin
      if (below)      target_nxt = dn_near;
      else if (above) target_nxt = up_near;
    end
  end

  assign cur_mask   = BIT0 << oFloor;
  assign step_floor = dir_up ? (oFloor + FLOOR_W'(1)) : (oFloor - FLOOR_W'(1));
  assign step_mask  = BIT0 << step_floor;

  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    dir_up_nxt = dir_up;
    floor_nxt  = oFloor;
    move_nxt   = oMove;
    door_nxt   = oDoor_open;
    arrive_nxt = 1'b0;
    req_clr    = '0;
    restart    = 1'b0;
    req_set    = iReq_stb ? iReq : '0;

    // A re-call of the floor whose door is open extends the dwell instead of queuing.
    if ((state == DOOR_OPEN) && ((req_set & cur_mask) != '0)) begin
      req_set = req_set & ~cur_mask;
      restart = 1'b1;
    end

    case (state)
      IDLE: begin
        timer_nxt = '0;
        if ((oPending & cur_mask) != '0) begin
          req_clr    = cur_mask;
          arrive_nxt = 1'b1;
          door_nxt   = 1'b1;
          state_nxt  = DOOR_OPEN;
        end else if (above && (dir_up || !below)) begin
          dir_up_nxt = 1'b1;
          move_nxt   = MV_UP;
          state_nxt  = MOVING;
        end else if (below) begin
          dir_up_nxt = 1'b0;
          move_nxt   = MV_DN;
          state_nxt  = MOVING;
        end
      end
      MOVING: begin
        if (timer == TRAVEL_LAST) begin
          timer_nxt = '0;
          floor_nxt = step_floor;
          if (((oPending | req_set) & step_mask) != '0) begin
            req_clr    = step_mask;
            arrive_nxt = 1'b1;
            door_nxt   = 1'b1;
            move_nxt   = MV_STOP;
            state_nxt  = DOOR_OPEN;
          end
        end else begin
          timer_nxt = timer + CNT_W'(1);
        end
      end
      DOOR_OPEN: begin
        if (restart) begin
          timer_nxt = '0;
        end else if (timer == DOOR_LAST) begin
          timer_nxt = '0;
          door_nxt  = 1'b0;
          if (dir_up ? above : below) begin
            move_nxt  = dir_up ? MV_UP : MV_DN;
            state_nxt = MOVING;
          end else if (dir_up ? below : above) begin
            dir_up_nxt = ~dir_up;
            move_nxt   = dir_up ? MV_DN : MV_UP;
            state_nxt  = MOVING;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          timer_nxt = timer + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    pending_nxt = (oPending | req_set) & ~req_clr;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state      <= IDLE;
      timer      <= '0;
      dir_up     <= 1'b1;
      oFloor     <= '0;
      oTarget    <= '0;
      oMove      <= MV_STOP;
      oDoor_open <= 1'b0;
      oPending   <= '0;
      oArrive    <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      dir_up     <= dir_up_nxt;
      oFloor     <= floor_nxt;
      oTarget    <= target_nxt;
      oMove      <= move_nxt;
      oDoor_open <= door_nxt;
      oPending   <= pending_nxt;
      oArrive    <= arrive_nxt;
    end
  end

  assign oDoor_closed = ~oDoor_open;

endmodule

// File: tb/tb_lift_scan_ctrl.sv
// Directed scenario bench for lift_scan_ctrl with FLOORS=9, TRAVEL_CYC=4, DOOR_CYC=6.
// Inputs change 1ns after a rising edge; outputs are checked at the same point.
`timescale 1ns/1ps
module tb_lift_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] req = '0;
  logic       req_stb = 1'b0;
  logic [3:0] floor_o, target_o;
  logic [1:0] move_o;
  logic       door_open_o, door_closed_o, arrive_o;
  logic [8:0] pending_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lift_scan_ctrl #(
    .FLOORS(9), .FLOOR_W(4), .CNT_W(8), .TRAVEL_CYC(4), .DOOR_CYC(6)
  ) dut (
    .iCLK(clk), .iRST_N(rst_n), .iReq(req), .iReq_stb(req_stb),
    .oFloor(floor_o), .oTarget(target_o), .oMove(move_o),
    .oDoor_open(door_open_o), .oDoor_closed(door_closed_o),
    .oPending(pending_o), .oArrive(arrive_o)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [8:0] r);
    req     = r;
    req_stb = 1'b1;
    step(1);
    req_stb = 1'b0;
    req     = '0;
  endtask

  task automatic wait_arrive(input int max, output int steps);
    steps = 0;
    for (int i = 0; i < max; i++) begin
      step(1);
      steps++;
      if (arrive_o === 1'b1) break;
    end
    total++;
    if (arrive_o !== 1'b1) begin
      bad++;
      $display("FAIL arrive_timeout: no oArrive within %0d cycles", max);
    end
  endtask

  task automatic count_door(input int start, output int cnt);
    cnt = start;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (door_open_o !== 1'b1) break;
      cnt++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(2);
    total++;
    if ({floor_o, target_o, move_o, door_open_o, door_closed_o, pending_o, arrive_o} !==
        {4'd0, 4'd0, 2'd0, 1'b0, 1'b1, 9'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_vals: got fl=%0d tg=%0d mv=%0d do=%b dc=%b pd=%h ar=%b",
               floor_o, target_o, move_o, door_open_o, door_closed_o, pending_o, arrive_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(2);
    total++;
    if (move_o !== 2'd0 || pending_o !== 9'd0) begin
      bad++;
      $display("FAIL reset_release: mv=%0d pd=%h, want 0/000", move_o, pending_o);
    end
  endtask

  task automatic test_single_up();
    int steps, cnt;
    strobe(9'h008);
    total++;
    if (pending_o !== 9'h008 || move_o !== 2'd0) begin
      bad++; $display("FAIL s1_latch: pd=%h mv=%0d, want 008/0", pending_o, move_o);
    end
    step(1);
    total++;
    if (move_o !== 2'd1 || target_o !== 4'd3) begin
      bad++; $display("FAIL s1_start: mv=%0d tg=%0d, want 1/3", move_o, target_o);
    end
    step(4);
    total++;
    if (floor_o !== 4'd1) begin bad++; $display("FAIL s1_floor1: got %0d want 1", floor_o); end
    step(4);
    total++;
    if (floor_o !== 4'd2) begin bad++; $display("FAIL s1_floor2: got %0d want 2", floor_o); end
    step(4);
    total++;
    if ({floor_o, arrive_o, door_open_o, door_closed_o, move_o, pending_o} !==
        {4'd3, 1'b1, 1'b1, 1'b0, 2'd0, 9'd0}) begin
      bad++;
      $display("FAIL s1_arrive: fl=%0d ar=%b do=%b dc=%b mv=%0d pd=%h",
               floor_o, arrive_o, door_open_o, door_closed_o, move_o, pending_o);
    end
    step(1);
    total++;
    if (arrive_o !== 1'b0) begin bad++; $display("FAIL s1_pulse: arrive still %b", arrive_o); end
    count_door(2, cnt);
    total++;
    if (cnt !== 6) begin bad++; $display("FAIL s1_door_len: got %0d want 6", cnt); end
    total++;
    if (move_o !== 2'd0 || pending_o !== 9'd0 || door_closed_o !== 1'b1) begin
      bad++; $display("FAIL s1_idle: mv=%0d pd=%h dc=%b", move_o, pending_o, door_closed_o);
    end
  endtask

  task automatic test_scan_reverse();
    int steps;
    strobe(9'h101);
    step(1);
    total++;
    if (move_o !== 2'd1 || target_o !== 4'd8) begin
      bad++; $display("FAIL s2_up_first: mv=%0d tg=%0d, want 1/8", move_o, target_o);
    end
    wait_arrive(40, steps);
    total++;
    if (steps !== 20 || floor_o !== 4'd8 || pending_o !== 9'h001) begin
      bad++; $display("FAIL s2_top: steps=%0d fl=%0d pd=%h, want 20/8/001", steps, floor_o, pending_o);
    end
    step(6);
    total++;
    if (move_o !== 2'd2 || door_open_o !== 1'b0) begin
      bad++; $display("FAIL s2_reverse: mv=%0d do=%b, want 2/0", move_o, door_open_o);
    end
    wait_arrive(60, steps);
    total++;
    if (steps !== 32 || floor_o !== 4'd0 || pending_o !== 9'd0) begin
      bad++; $display("FAIL s2_bottom: steps=%0d fl=%0d pd=%h, want 32/0/000", steps, floor_o, pending_o);
    end
    step(6);
    total++;
    if (move_o !== 2'd0 || door_open_o !== 1'b0) begin
      bad++; $display("FAIL s2_idle: mv=%0d do=%b", move_o, door_open_o);
    end
  endtask

  task automatic test_intermediate_stop();
    int steps;
    strobe(9'h020);
    step(1);
    total++;
    if (move_o !== 2'd1) begin bad++; $display("FAIL s3_start: mv=%0d want 1", move_o); end
    step(4);
    total++;
    if (floor_o !== 4'd1) begin bad++; $display("FAIL s3_floor1: got %0d want 1", floor_o); end
    strobe(9'h004);
    total++;
    if (pending_o !== 9'h024) begin bad++; $display("FAIL s3_latch: pd=%h want 024", pending_o); end
    wait_arrive(20, steps);
    total++;
    if (steps !== 3 || floor_o !== 4'd2 || pending_o !== 9'h020 || move_o !== 2'd0) begin
      bad++; $display("FAIL s3_stop2: steps=%0d fl=%0d pd=%h mv=%0d", steps, floor_o, pending_o, move_o);
    end
    step(6);
    total++;
    if (move_o !== 2'd1 || door_open_o !== 1'b0) begin
      bad++; $display("FAIL s3_resume: mv=%0d do=%b, want 1/0", move_o, door_open_o);
    end
    wait_arrive(30, steps);
    total++;
    if (steps !== 12 || floor_o !== 4'd5 || pending_o !== 9'd0) begin
      bad++; $display("FAIL s3_stop5: steps=%0d fl=%0d pd=%h, want 12/5/000", steps, floor_o, pending_o);
    end
    step(6);
  endtask

  task automatic test_door_extend();
    int steps, cnt;
    strobe(9'h010);
    step(1);
    total++;
    if (move_o !== 2'd2) begin bad++; $display("FAIL s4_down: mv=%0d want 2", move_o); end
    wait_arrive(20, steps);
    total++;
    if (floor_o !== 4'd4 || steps !== 4) begin
      bad++; $display("FAIL s4_arrive: fl=%0d steps=%0d, want 4/4", floor_o, steps);
    end
    step(4);
    strobe(9'h010);
    total++;
    if (pending_o !== 9'd0 || door_open_o !== 1'b1) begin
      bad++; $display("FAIL s4_relatch: pd=%h do=%b, want 000/1", pending_o, door_open_o);
    end
    count_door(6, cnt);
    total++;
    if (cnt !== 11) begin bad++; $display("FAIL s4_door_len: got %0d want 11", cnt); end
    total++;
    if (move_o !== 2'd0 || pending_o !== 9'd0) begin
      bad++; $display("FAIL s4_idle: mv=%0d pd=%h", move_o, pending_o);
    end
  endtask

  task automatic test_same_floor();
    int steps, cnt;
    bit moved;
    strobe(9'h040);
    wait_arrive(30, steps);
    step(6);
    total++;
    if (floor_o !== 4'd6 || move_o !== 2'd0) begin
      bad++; $display("FAIL s5_setup: fl=%0d mv=%0d, want 6/0", floor_o, move_o);
    end
    strobe(9'h040);
    total++;
    if (pending_o !== 9'h040 || arrive_o !== 1'b0) begin
      bad++; $display("FAIL s5_latch: pd=%h ar=%b, want 040/0", pending_o, arrive_o);
    end
    step(1);
    total++;
    if (arrive_o !== 1'b1 || door_open_o !== 1'b1 || pending_o !== 9'd0 || move_o !== 2'd0) begin
      bad++; $display("FAIL s5_open: ar=%b do=%b pd=%h mv=%0d", arrive_o, door_open_o, pending_o, move_o);
    end
    cnt = 1;
    moved = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (move_o !== 2'd0) moved = 1'b1;
      if (door_open_o !== 1'b1) break;
      cnt++;
    end
    total++;
    if (cnt !== 6 || moved || floor_o !== 4'd6) begin
      bad++; $display("FAIL s5_dwell: cnt=%0d moved=%b fl=%0d, want 6/0/6", cnt, moved, floor_o);
    end
  endtask

  task automatic test_reset_mid_move();
    strobe(9'h011);
    step(1);
    total++;
    if (move_o !== 2'd2 || pending_o !== 9'h011) begin
      bad++; $display("FAIL s6_moving: mv=%0d pd=%h, want 2/011", move_o, pending_o);
    end
    step(2);
    rst_n = 1'b0;
    #1;
    total++;
    if ({floor_o, pending_o, door_closed_o, door_open_o, move_o, target_o, arrive_o} !==
        {4'd0, 9'd0, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0}) begin
      bad++;
      $display("FAIL s6_async_rst: fl=%0d pd=%h dc=%b do=%b mv=%0d tg=%0d ar=%b",
               floor_o, pending_o, door_closed_o, door_open_o, move_o, target_o, arrive_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(3);
    total++;
    if (move_o !== 2'd0 || pending_o !== 9'd0 || floor_o !== 4'd0) begin
      bad++; $display("FAIL s6_after: mv=%0d pd=%h fl=%0d", move_o, pending_o, floor_o);
    end
  endtask

  initial begin
    test_reset();
    test_single_up();
    test_scan_reverse();
    test_intermediate_stop();
    test_door_extend();
    test_same_floor();
    test_reset_mid_move();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
